// File: rtl/ftdi_pkg.sv
// ----------------------------------------------------------------------------
// ftdi_pkg
// Shared definitions for the FTDI transmit-side blocks.
//   - state_t    : 3-bit encoding of the transmit arbiter state machine
//                  (ST_IDLE, ST_TAG_RQ, ST_TAG_REL, ST_TX_RQ, ST_TX_REL, ST_ACK)
//   - TAG_BASE_DEFAULT : default upper nibble of the channel tag byte
//   - clog2()    : index width helper, usable in parameter expressions
// The tag states are only reachable when FTDI_TAG_EN is defined.
// ----------------------------------------------------------------------------
package ftdi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TAG_RQ  = 3'd1,
        ST_TAG_REL = 3'd2,
        ST_TX_RQ   = 3'd3,
        ST_TX_REL  = 3'd4,
        ST_ACK     = 3'd5
    } state_t;

    localparam logic [7:0] TAG_BASE_DEFAULT = 8'hA0;

    // Smallest r with 2**r >= v; returns 1 for v <= 2 so that index
    // vectors are never zero width.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ftdi_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// ftdi_tx_arbiter_if
// Bundles the requester-side and FTDI-side handshake signals of the
// transmit arbiter.
//   req_data [8*N_REQ] : byte of requester i on bits [8i+7:8i]
//   req_rq   [N_REQ]   : requester i has a byte pending
//   req_st   [N_REQ]   : one-hot, byte of requester i delivered
//   tx_data  [8]       : byte presented to the FTDI block
//   tx_rq              : request toward the FTDI block
//   tx_st              : FTDI block has taken the byte
// Modports:
//   master : arbiter view
//   slave  : environment view (requesters + FTDI block)
// ----------------------------------------------------------------------------
interface ftdi_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_rq;
    logic [N_REQ-1:0]   req_st;
    logic [7:0]         tx_data;
    logic               tx_rq;
    logic               tx_st;

    modport master (
        input  req_data,
        input  req_rq,
        input  tx_st,
        output req_st,
        output tx_data,
        output tx_rq
    );

    modport slave (
        output req_data,
        output req_rq,
        output tx_st,
        input  req_st,
        input  tx_data,
        input  tx_rq
    );
endinterface

// File: rtl/ftdi_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder.
// Searches req starting one position after 'last' and wrapping modulo
// N_REQ; the requester at 'last' itself is checked last, so a requester
// that was just served only wins again when nobody else is asking.
//   req   [N_REQ] : request vector
//   last  [IW]    : index of the most recently served requester
//   valid         : at least one request bit is set
//   idx   [IW]    : index of the winning requester (0 when !valid)
// ----------------------------------------------------------------------------
module rr_pick
    import ftdi_pkg::*;
#(
    parameter int  N_REQ = 4,
    localparam int IW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    always_comb begin
        logic [IW:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            // last < N_REQ and k <= N_REQ, so one subtraction wraps it.
            cand = {1'b0, last} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (!valid && req[cand[IW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// ----------------------------------------------------------------------------
// ftdi_tx_arbiter
// Shares the single FTDI transmit channel between N_REQ requesters with
// round-robin arbitration, one byte per grant. Toward the FTDI block it
// replays the tx_rq/tx_st four-phase handshake; toward each requester it
// offers the same handshake on req_rq/req_st.
//
// Ports:
//   clock_in : system clock (all inputs sampled directly, no synchronisers)
//   reset    : synchronous, active-high
//   bus      : ftdi_tx_arbiter_if.master (req_data, req_rq, req_st,
//              tx_data, tx_rq, tx_st)
//
// Parameters:
//   N_REQ    : number of requesters, 2..16
//   TAG_BASE : upper nibble of the channel tag byte, low nibble must be 0
//
// Build option FTDI_TAG_EN: when defined, every grant first sends the tag
// byte TAG_BASE | gnt through TAG_RQ/TAG_REL, then the data byte; req_st
// pulses only after the data byte. When undefined the state machine is
// IDLE -> TX_RQ -> TX_REL -> ACK.
// ----------------------------------------------------------------------------
module ftdi_tx_arbiter
    import ftdi_pkg::*;
#(
    parameter int         N_REQ    = 4,
    parameter logic [7:0] TAG_BASE = TAG_BASE_DEFAULT
) (
    input  logic              clock_in,
    input  logic              reset,
    ftdi_tx_arbiter_if.master bus
);

    localparam int IW = clog2(N_REQ);

    if (N_REQ < 2) begin : g_nreq_too_small
        $error("ftdi_tx_arbiter: N_REQ must be at least 2");
    end

    if (TAG_BASE[3:0] != 4'h0) begin : g_tag_base_bad
        $error("ftdi_tx_arbiter: TAG_BASE low nibble must be zero");
    end

`ifdef FTDI_TAG_EN
    // The requester index must fit the low nibble of the tag byte.
    if (N_REQ > 16) begin : g_nreq_too_big
        $error("ftdi_tx_arbiter: N_REQ above 16 cannot be tagged");
    end
`endif

    state_t             state_q, state_d;
    logic [IW-1:0]      gnt_q, gnt_d;
    logic [IW-1:0]      last_grant_q, last_grant_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_rq_q, tx_rq_d;
    logic [N_REQ-1:0]   req_st_q, req_st_d;
`ifdef FTDI_TAG_EN
    // Data byte parked here while the tag byte occupies tx_data.
    logic [7:0]         byte_q, byte_d;
`endif

    logic               pick_vld;
    logic [IW-1:0]      pick_idx;
    logic [7:0]         pick_data;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (bus.req_rq),
        .last  (last_grant_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign pick_data = bus.req_data[{pick_idx, 3'b000} +: 8];

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        tx_data_d    = tx_data_q;
        tx_rq_d      = tx_rq_q;
        req_st_d     = req_st_q;
`ifdef FTDI_TAG_EN
        byte_d       = byte_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_idx;
                    tx_rq_d = 1'b1;
`ifdef FTDI_TAG_EN
                    tx_data_d = TAG_BASE | 8'(pick_idx);
                    byte_d    = pick_data;
                    state_d   = ST_TAG_RQ;
`else
                    tx_data_d = pick_data;
                    state_d   = ST_TX_RQ;
`endif
                end
            end

`ifdef FTDI_TAG_EN
            ST_TAG_RQ: begin
                if (bus.tx_st) begin
                    tx_rq_d = 1'b0;
                    state_d = ST_TAG_REL;
                end
            end

            ST_TAG_REL: begin
                if (!bus.tx_st) begin
                    tx_data_d = byte_q;
                    tx_rq_d   = 1'b1;
                    state_d   = ST_TX_RQ;
                end
            end
`endif

            // No timeout: FTDI txe gating may hold tx_st low for a long time.
            ST_TX_RQ: begin
                if (bus.tx_st) begin
                    tx_rq_d = 1'b0;
                    state_d = ST_TX_REL;
                end
            end

            ST_TX_REL: begin
                if (!bus.tx_st) begin
                    req_st_d = (N_REQ)'(1) << gnt_q;
                    state_d  = ST_ACK;
                end
            end

            // If the requester already dropped req_rq during the transfer,
            // req_st is high for exactly one cycle.
            ST_ACK: begin
                if (!bus.req_rq[gnt_q]) begin
                    req_st_d     = '0;
                    last_grant_d = gnt_q;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                tx_rq_d  = 1'b0;
                req_st_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            // Requester 0 wins the first arbitration after reset.
            last_grant_q <= IW'(N_REQ - 1);
            tx_data_q    <= 8'h00;
            tx_rq_q      <= 1'b0;
            req_st_q     <= '0;
`ifdef FTDI_TAG_EN
            byte_q       <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            tx_data_q    <= tx_data_d;
            tx_rq_q      <= tx_rq_d;
            req_st_q     <= req_st_d;
`ifdef FTDI_TAG_EN
            byte_q       <= byte_d;
`endif
        end
    end

    assign bus.tx_data = tx_data_q;
    assign bus.tx_rq   = tx_rq_q;
    assign bus.req_st  = req_st_q;

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ftdi_tx_arbiter
// Directed bench for ftdi_tx_arbiter with N_REQ = 4. The initial block plays
// both the requesters and the FTDI block. When FTDI_TAG_EN is defined each
// grant expects the tag byte TAG_BASE | index ahead of the data byte.
// ----------------------------------------------------------------------------
module tb_ftdi_tx_arbiter;

    localparam int         N_REQ    = 4;
    localparam logic [7:0] TAG_BASE = 8'hA0;

    logic clock_in = 1'b0;
    logic reset;

    int passed = 0;
    int total  = 0;
    int waited = 0;

    ftdi_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    ftdi_tx_arbiter #(
        .N_REQ    (N_REQ),
        .TAG_BASE (TAG_BASE)
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic tick();
        @(posedge clock_in);
        #1;
        chk("st_onehot", 32'($onehot0(bus.req_st)), 32'h1);
        chk("rq_st_excl", 32'(bus.tx_rq & (|bus.req_st)), 32'h0);
    endtask

    // FTDI side of one byte: wait (bounded) for tx_rq, check the byte, hold
    // tx_st low for 'delay' cycles, then take it and release tx_st.
    // 'drop' >= 0 drops that requester's req_rq once tx_rq is seen.
    task automatic ftdi_byte(input logic [7:0] exp, input int delay, input int drop,
                             input string tag);
        int n;
        n = 0;
        while (bus.tx_rq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        waited = n;
        chk({tag, "_rq"}, 32'(bus.tx_rq), 32'h1);
        chk({tag, "_data"}, 32'(bus.tx_data), 32'(exp));
        if (drop >= 0) bus.req_rq[drop[1:0]] = 1'b0;
        for (int i = 0; i < delay; i++) begin
            tick();
            chk({tag, "_hold_rq"}, 32'(bus.tx_rq), 32'h1);
            chk({tag, "_hold_data"}, 32'(bus.tx_data), 32'(exp));
            chk({tag, "_hold_st"}, 32'(bus.req_st), 32'h0);
        end
        bus.tx_st = 1'b1;
        tick();
        chk({tag, "_rq_fall"}, 32'(bus.tx_rq), 32'h0);
        chk({tag, "_no_st"}, 32'(bus.req_st), 32'h0);
        bus.tx_st = 1'b0;
    endtask

    // One full grant: optional tag byte, data byte, then req_st for idx.
    task automatic grant(input int idx, input logic [7:0] d, input int delay,
                         input int drop, input string tag);
`ifdef FTDI_TAG_EN
        ftdi_byte(TAG_BASE | 8'(idx), delay, -1, {tag, "_tag"});
`endif
        ftdi_byte(d, delay, drop, tag);
        tick();
        chk({tag, "_st"}, 32'(bus.req_st), 32'h1 << idx);
    endtask

    // Requester completes the four-phase handshake; optionally re-requests.
    task automatic release_rq(input int idx, input bit reraise, input string tag);
        bus.req_rq[idx[1:0]] = 1'b0;
        tick();
        chk({tag, "_st_clr"}, 32'(bus.req_st), 32'h0);
        chk({tag, "_idle_rq"}, 32'(bus.tx_rq), 32'h0);
        if (reraise) bus.req_rq[idx[1:0]] = 1'b1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.req_data = '0;
        bus.req_rq   = '0;
        bus.tx_st    = 1'b0;
        tick();
        tick();
        chk("reset_tx_rq", 32'(bus.tx_rq), 32'h0);
        chk("reset_tx_data", 32'(bus.tx_data), 32'h0);
        chk("reset_req_st", 32'(bus.req_st), 32'h0);
        reset = 1'b0;
        tick();
        chk("idle_tx_rq", 32'(bus.tx_rq), 32'h0);

        // Single request, FTDI answers 3 cycles after tx_rq.
        bus.req_data[7:0] = 8'h55;
        bus.req_rq        = 4'b0001;
        grant(0, 8'h55, 3, -1, "single");
        chk("single_latency", 32'(waited), 32'h1);
        tick();
        chk("single_st_hold", 32'(bus.req_st), 32'h1);
        release_rq(0, 1'b0, "single");

        // Rotation with wrap-around: last grant 1, then 0 and 1 both request.
        bus.req_data[15:8] = 8'h21;
        bus.req_rq         = 4'b0010;
        grant(1, 8'h21, 0, -1, "rot_a");
        release_rq(1, 1'b0, "rot_a");
        bus.req_data[7:0] = 8'h20;
        bus.req_rq        = 4'b0011;
        grant(0, 8'h20, 0, -1, "rot_skip");
        release_rq(0, 1'b0, "rot_skip");
        grant(1, 8'h21, 0, -1, "rot_b");
        release_rq(1, 1'b0, "rot_b");

        // Reset during the request phase aborts it.
        bus.req_data[23:16] = 8'h77;
        bus.req_rq          = 4'b0100;
        tick();
        chk("rst_mid_pre_rq", 32'(bus.tx_rq), 32'h1);
        reset = 1'b1;
        tick();
        chk("rst_mid_tx_rq", 32'(bus.tx_rq), 32'h0);
        chk("rst_mid_req_st", 32'(bus.req_st), 32'h0);
        chk("rst_mid_tx_data", 32'(bus.tx_data), 32'h0);
        reset = 1'b0;

        // All four requesting continuously: strict rotation from requester 0.
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req_rq   = 4'b1111;
        grant(0, 8'h10, 1, -1, "rr0");
        release_rq(0, 1'b1, "rr0");
        grant(1, 8'h11, 1, -1, "rr1");
        release_rq(1, 1'b1, "rr1");
        grant(2, 8'h12, 1, -1, "rr2");
        release_rq(2, 1'b1, "rr2");
        grant(3, 8'h13, 1, -1, "rr3");
        release_rq(3, 1'b1, "rr3");
        grant(0, 8'h10, 1, -1, "rr4");
        release_rq(0, 1'b0, "rr4");
        bus.req_rq = 4'b0000;

        // Requester withdraws while its byte is pending: byte still goes out
        // and req_st is a single-cycle pulse.
        bus.req_data[23:16] = 8'h77;
        bus.req_rq          = 4'b0100;
        grant(2, 8'h77, 2, 2, "drop");
        tick();
        chk("drop_st_clr", 32'(bus.req_st), 32'h0);
        chk("drop_idle_rq", 32'(bus.tx_rq), 32'h0);

        // FTDI stalls for 200 cycles.
        bus.req_data[31:24] = 8'h99;
        bus.req_rq          = 4'b1000;
        grant(3, 8'h99, 200, -1, "stall");
        release_rq(3, 1'b0, "stall");

        // Requester 2 alone; with tagging the tag byte A2 precedes 3C.
        bus.req_data[23:16] = 8'h3C;
        bus.req_rq          = 4'b0100;
        grant(2, 8'h3C, 2, -1, "tagged");
        release_rq(2, 1'b0, "tagged");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ftdi_tx_arbiter.md
Name: ftdi_tx_arbiter

Overview:
Shares the single Mercurial-to-PC transmit channel of the FTDI interface block between N_REQ on-chip requesters.
Arbitration is round-robin, one byte per grant. The block replays the FTDI block's tx_rq/tx_st handshake toward it and offers the same four-phase handshake to each requester.
Sits between the requester logic and the FTDI block, in the same clock domain.

Parameters:
N_REQ, 4, number of requesters, 2..16
TAG_BASE, 8'hA0, upper nibble of the channel tag byte; low nibble must be 0 (used only with FTDI_TAG_EN)

Ports:
clock_in  input  1  system clock
reset  input  1  synchronous, active-high reset
req_data  input  8*N_REQ  byte from requester i on bits [8i+7:8i]
req_rq  input  N_REQ  requester i high = byte pending; data held stable while high
req_st  output  N_REQ  one-hot strobe: byte of requester i delivered to FTDI block
tx_data  output  8  byte to FTDI block tx_data
tx_rq  output  1  to FTDI block tx_rq
tx_st  input  1  from FTDI block tx_st; high = byte taken

Behaviour:
- Reset: tx_rq=0, tx_data=8'h00, req_st=0, state=IDLE, last_grant=N_REQ-1 so requester 0 wins first.
- Reset asserted in any state aborts the transfer on the next edge. The system drives the same reset to the FTDI block.
- All inputs are sampled directly on clock_in; there are no synchronisers.
- IDLE:
  - If any req_rq bit is set, grant the first set bit searching last_grant+1, +2, … modulo N_REQ.
  - Latch grant index into gnt and req_data[gnt] into the data register.
  - Go to TX_RQ; tx_rq rises on the same edge.
  - Grant decision latency: 1 cycle from req_rq high in IDLE to tx_rq high.
- TX_RQ: hold tx_rq=1 and tx_data stable. On tx_st==1: tx_rq<=0, go to TX_REL.
- TX_REL: wait for tx_st==0, then go to ACK with req_st[gnt]<=1.
- ACK:
  - Hold req_st[gnt]=1 until req_rq[gnt]==0.
  - Then req_st<=0, last_grant<=gnt, go to IDLE.
  - The next grant decision is taken in IDLE on the following cycle. Minimum 1 idle cycle between bytes.
- Only the granted requester's req_rq/req_data are observed after grant. Changes on other lines have no effect until IDLE.
- If req_rq[gnt] drops while in TX_RQ or TX_REL: the byte still completes; the ACK exit condition is met immediately.
- Simultaneous requests: strict rotation. With all N_REQ requesting continuously, each gets exactly one byte per N_REQ grants.
- req_st is never multi-hot. tx_rq and req_st are never both high.
- Throughput is limited by the FTDI block's txe gating. The arbiter waits in TX_RQ indefinitely; there is no timeout.

Optional Feature:
FTDI_TAG_EN
- Defined:
  - Each grant emits two bytes: first tag = TAG_BASE | gnt (4-bit index, zero-extended), then the data byte.
  - Added states TAG_RQ and TAG_REL run the same tx_rq/tx_st handshake before TX_RQ.
  - req_st pulses only after the data byte.
  - N_REQ above 16 is rejected with an elaboration error.
- Undefined: no tag byte; the state machine is IDLE, TX_RQ, TX_REL, ACK only.

Decomposition:
- Shared package ftdi_pkg:
  - state encoding localparams (ST_IDLE, ST_TAG_RQ, ST_TAG_REL, ST_TX_RQ, ST_TX_REL, ST_ACK, 3 bits)
  - TAG_BASE default
  - clog2 function for the index width
- One sub-module: rr_pick.
  - Combinational round-robin priority encoder.
  - Inputs: req vector and last index. Outputs: valid and next index.
  - Reused by future rx demux / multi-channel blocks.

Test Plan:
- Single request: req_rq=4'b0001, req_data[0]=8'h55; a model FTDI raises tx_st 3 cycles after tx_rq -> tx_data=8'h55 while tx_rq=1; req_st=4'b0001 after tx_st falls; cleared after req_rq[0] drops.
- Round-robin: req_rq=4'b1111 held, data 8'h10/11/12/13 -> byte order 10,11,12,13,10,…; req_st one-hot in matching order.
- Rotation skip: last_grant=1, req_rq=4'b0011 -> requester 0 granted next (2 and 3 idle, wrap-around).
- Reset mid-transfer: reset asserted during TX_RQ -> next edge tx_rq=0, req_st=0; after release, requester 0 has priority.
- Stall: tx_st held 0 for 200 cycles -> tx_rq stays 1, tx_data unchanged, no req_st; completes normally when tx_st pulses.
- FTDI_TAG_EN defined: req_rq=4'b0100, data 8'h3C -> tx sequence 8'hA2 then 8'h3C; single req_st[2] pulse after 8'h3C only.
